cbus_rr_arbiter: RTL and testbench
==================================

Name: cbus_rr_arbiter

Overview:
- Round-robin arbiter that shares one CBus master port (cbus_req_t / cbus_resp_t) among NUM_INPUTS requesters, such as the I-cache, the D-cache and the uncached path.
- Guarantees fairness: no requester is starved, unlike fixed-index priority.
- Forwards the live request of the granted requester for the whole transaction, so per-beat write data reaches the bus.
- Sits between the cache/uncached units and the top-level CBus-to-AXI bridge.

Parameters:
- NUM_INPUTS, 2, number of requesters; legal range 1..16.
- IDX_W, $clog2(NUM_INPUTS) (minimum 1), localparam, width of the grant index.

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- ireqs  in  cbus_req_t[NUM_INPUTS]  requests from the requesters.
- iresps  out  cbus_resp_t[NUM_INPUTS]  responses routed back to the requesters.
- oreq  out  cbus_req_t  request to the shared bus.
- oresp  in  cbus_resp_t  response from the shared bus.
- busy  out  1  a transaction is granted and in flight.
- grant_idx  out  IDX_W  index of the current or most recent grantee.

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, busy=0, grant_idx=0, rr_ptr=0, counters cleared. While in reset: oreq='0 and every iresps[i]='0.
- FSM states: IDLE, GRANT, BUSY.
- IDLE:
  - oreq='0; all iresps='0.
  - Winner = first i with ireqs[i].valid=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_INPUTS.
  - If a winner exists: grant_idx<=winner, then go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - Lasts exactly one cycle; oreq='0.
  - Next state is BUSY; busy=1 from this cycle on.
  - Purpose: no request reaches the bus in the cycle it is selected (prevents early issue).
- BUSY:
  - oreq=ireqs[grant_idx], passed through combinationally each cycle.
  - iresps[grant_idx]=oresp; every other iresps[j]='0.
  - On oresp.last=1 (sampled together with ready): state<=IDLE, busy<=0 in the next cycle, rr_ptr<=(grant_idx+1) mod NUM_INPUTS.
- Latency:
  - A request arriving with the arbiter in IDLE appears on oreq 2 cycles later.
  - After last, the earliest next grant is selected 1 cycle after returning to IDLE.
- Requester protocol:
  - A requester must hold valid until it sees last.
  - If the grantee drops valid mid-transaction, the arbiter stays in BUSY and keeps forwarding. oreq.valid then goes to 0 and no further handshake occurs. Recovery is by reset only.
- Simultaneous events:
  - Requests that assert while BUSY wait; they are never lost.
  - A new valid from the grantee in the same cycle as last is not granted back-to-back if another requester is pending, because rr_ptr has advanced past it.
- NUM_INPUTS=1: degenerates to GRANT/BUSY cycling on requester 0; grant_idx is always 0.
- Non-grantee iresps are held at zero, so an idle requester never sees ready or last.
- Reset mid-transaction: immediate abort; outputs drop to their reset values asynchronously. The bus is expected to be reset together with the arbiter.
- Out-of-range grant_idx is unreachable. Verification asserts grant_idx<NUM_INPUTS always.

Optional Feature:
- Macro: CBUS_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt, type logic[NUM_INPUTS][15:0].
  - grant_cnt[i] increments by 1 on each IDLE->GRANT transition that selects requester i.
  - Saturates at 16'hFFFF; reset value 0. For performance counters and debug.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Test Plan:
- Single request:
  - Stimulus: ireqs[1].valid=1 at cycle 0 with NUM_INPUTS=2; bus returns last at cycle 4.
  - Required: oreq valid at cycle 2; iresps[1] mirrors oresp; iresps[0]=0; busy deasserts at cycle 5; rr_ptr=0.
- Round-robin fairness:
  - Stimulus: NUM_INPUTS=3, all three valid continuously, each transaction 1 beat.
  - Required: grant order 0,1,2,0,1,2; no index granted twice before the others.
- Back-to-back re-request:
  - Stimulus: requester 0 re-asserts valid in the same cycle as its last while requester 1 is pending.
  - Required: the next grant goes to 1.
- Burst passthrough:
  - Stimulus: 4-beat write from requester 1 whose data changes every beat.
  - Required: oreq.data tracks ireqs[1].data on every beat; exactly 4 ready pulses; last on the 4th.
- Asynchronous reset mid-BUSY:
  - Stimulus: drop resetn between clock edges during beat 2.
  - Required: oreq and iresps go to '0 and busy=0 immediately, with no clock edge needed; after release, state is IDLE, rr_ptr=0, and the first grant goes to requester 0.
- Stats (CBUS_ARB_STATS_EN defined):
  - Stimulus: 5 grants to requester 0 and 3 to requester 1.
  - Required: grant_cnt[0]=5 and grant_cnt[1]=3.
  - Additional: a preloaded 16'hFFFF does not wrap.

Source files
------------

// File: rtl/cbus_rr_arbiter.sv
// Round-robin CBus arbiter: request reaches oreq 2 cycles after selection, then oreq/oresp pass through to the grantee until last.
// Non-grantees wait with zeroed responses; define CBUS_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt).
package cbus_pkg;
   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
      logic        last;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;
endpackage

module cbus_rr_arbiter
   import cbus_pkg::*;
#(
   parameter  int NUM_INPUTS = 2,
   localparam int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  cbus_req_t        ireqs  [NUM_INPUTS],
   output cbus_resp_t       iresps [NUM_INPUTS],
   output cbus_req_t        oreq,
   input  cbus_resp_t       oresp,
   output logic             busy,
   output logic [IDX_W-1:0] grant_idx
`ifdef CBUS_ARB_STATS_EN
   ,
   output logic [NUM_INPUTS-1:0][15:0] grant_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             win_vld;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W:0]   cand;
   logic [IDX_W:0]   ptr_inc;
   logic             bus_done;

   assign bus_done = oresp.ready & oresp.last;

   // Scan from the farthest offset down so the requester closest to rr_ptr wins.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_INPUTS)) begin
            cand = cand - (IDX_W+1)'(NUM_INPUTS);
         end
         if (ireqs[cand[IDX_W-1:0]].valid) begin
            win_vld = 1'b1;
            win_idx = cand[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         grant_idx_q <= '0;
         rr_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   always_comb begin
      ptr_inc = {1'b0, grant_idx_q} + (IDX_W+1)'(1);
      if (ptr_inc >= (IDX_W+1)'(NUM_INPUTS)) begin
         ptr_inc = '0;
      end
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      rr_ptr_d    = rr_ptr_q;
      unique case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d     = GRANT;
               grant_idx_d = win_idx;
            end
         end
         GRANT: state_d = BUSY;
         BUSY: begin
            if (bus_done) begin
               state_d  = IDLE;
               rr_ptr_d = ptr_inc[IDX_W-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // GRANT deliberately keeps oreq at zero so a freshly selected request never issues early.
   always_comb begin
      oreq = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         iresps[i] = '0;
      end
      if (state_q == BUSY) begin
         oreq                = ireqs[grant_idx_q];
         iresps[grant_idx_q] = oresp;
      end
   end

   assign busy      = (state_q != IDLE);
   assign grant_idx = grant_idx_q;

`ifdef CBUS_ARB_STATS_EN
   logic [NUM_INPUTS-1:0][15:0] grant_cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         grant_cnt_q <= '0;
      end else if ((state_q == IDLE) && win_vld && (grant_cnt_q[win_idx] != 16'hFFFF)) begin
         grant_cnt_q[win_idx] <= grant_cnt_q[win_idx] + 16'd1;
      end
   end

   assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter: directed scenarios plus random traffic against a pointer/priority-set model.
module tb_cbus_rr_arbiter;
   import cbus_pkg::*;

   localparam int N  = 3;
   localparam int IW = 2;

   logic          clk;
   logic          resetn;
   cbus_req_t     ireqs  [N];
   cbus_resp_t    iresps [N];
   cbus_req_t     oreq;
   cbus_resp_t    oresp;
   logic          busy;
   logic [IW-1:0] grant_idx;
`ifdef CBUS_ARB_STATS_EN
   logic [N-1:0][15:0] grant_cnt;
`endif

   cbus_rr_arbiter #(.NUM_INPUTS(N)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .ireqs     (ireqs),
      .iresps    (iresps),
      .oreq      (oreq),
      .oresp     (oresp),
      .busy      (busy),
      .grant_idx (grant_idx)
`ifdef CBUS_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   int n_chk = 0;
   int n_bad = 0;
   bit want   [N];
   int len    [N];
   int cnt_m  [N];
   int ptr_m  = 0;
   int last_g = 0;
   int len_fix = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference arbitration: first wanting requester at or after the pointer, wrapping.
   function automatic int pick();
      for (int k = 0; k < N; k++) begin
         int j;
         j = (ptr_m + k) % N;
         if (want[j]) return j;
      end
      return -1;
   endfunction

   task automatic raise(input int j);
      want[j]           = 1'b1;
      len[j]            = (len_fix != 0) ? len_fix : int'($urandom_range(4, 1));
      ireqs[j].valid    = 1'b1;
      ireqs[j].is_write = 1'($urandom_range(1));
      ireqs[j].size     = 3'($urandom_range(7));
      ireqs[j].addr     = $urandom;
      ireqs[j].strb     = 4'($urandom_range(15));
      ireqs[j].data     = $urandom;
      ireqs[j].last     = 1'($urandom_range(1));
   endtask

   task automatic drop(input int j);
      want[j]  = 1'b0;
      ireqs[j] = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      @(negedge clk);
      chk({tag, "_busy"}, 128'(busy), 128'(0));
      chk({tag, "_oreq"}, 128'(oreq), 128'(0));
      chk({tag, "_gidx"}, 128'(grant_idx), 128'(last_g));
      chk({tag, "_gidx_range"}, 128'(32'(grant_idx) < N), 128'(1));
      for (int j = 0; j < N; j++) chk({tag, "_iresp"}, 128'(iresps[j]), 128'(0));
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      for (int j = 0; j < N; j++) begin
         drop(j);
         cnt_m[j] = 0;
      end
      oresp  = '0;
      ptr_m  = 0;
      last_g = 0;
      repeat (2) tick();
      @(negedge clk);
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_oreq", 128'(oreq), 128'(0));
      chk("rst_gidx", 128'(grant_idx), 128'(0));
      resetn = 1'b1;
      tick();
   endtask

   // One transaction from an IDLE selection cycle through last (or an abort at abort_beat).
   task automatic run_txn(output int w, output int pulses, output int last_at,
                          input int stall_pct, input int keep_pct, input int raise_pct,
                          input int abort_beat);
      int  beats;
      int  txlen;
      bit  rdy;
      bit  fin;
      w = pick();
      if (w < 0) begin
         raise(0);
         w = pick();
      end
      txlen   = len[w];
      pulses  = 0;
      last_at = 0;
      beats   = 0;
      fin     = 1'b0;
      chk_idle("sel");
      if (cnt_m[w] < 65535) cnt_m[w]++;
      tick();
      @(negedge clk);
      chk("grant_busy", 128'(busy), 128'(1));
      chk("grant_gidx", 128'(grant_idx), 128'(w));
      chk("grant_oreq", 128'(oreq), 128'(0));
      for (int j = 0; j < N; j++) chk("grant_iresp", 128'(iresps[j]), 128'(0));
      last_g = w;
      tick();
      for (int c = 0; c < 200; c++) begin
         ireqs[w].data = $urandom;
         rdy           = (c >= 150) ? 1'b1 : ($urandom_range(99) >= stall_pct);
         fin           = rdy && (beats == txlen - 1);
         oresp.ready   = rdy;
         oresp.last    = fin;
         oresp.data    = $urandom;
         for (int j = 0; j < N; j++) begin
            if (j != w && !want[j] && $urandom_range(99) < raise_pct) raise(j);
         end
         @(negedge clk);
         chk("beat_oreq", 128'(oreq), 128'(ireqs[w]));
         chk("beat_busy", 128'(busy), 128'(1));
         for (int j = 0; j < N; j++) begin
            if (j == w) chk("beat_iresp_g", 128'(iresps[j]), 128'(oresp));
            else        chk("beat_iresp_o", 128'(iresps[j]), 128'(0));
         end
         if (iresps[w].ready) begin
            pulses++;
            if (iresps[w].last) last_at = pulses;
         end
         if (rdy) beats++;
         if (abort_beat >= 0 && beats == abort_beat) begin
            #1;
            resetn = 1'b0;
            #1;
            chk("abort_oreq", 128'(oreq), 128'(0));
            chk("abort_busy", 128'(busy), 128'(0));
            chk("abort_gidx", 128'(grant_idx), 128'(0));
            for (int j = 0; j < N; j++) chk("abort_iresp", 128'(iresps[j]), 128'(0));
            oresp = '0;
            return;
         end
         tick();
         if (fin) break;
      end
      oresp = '0;
      chk("txn_pulses", 128'(pulses), 128'(txlen));
      ptr_m = (w + 1) % N;
      if ($urandom_range(99) < keep_pct) raise(w);
      else                               drop(w);
   endtask

   initial begin
      int w, p, la;
      resetn = 1'b0;
      oresp  = '0;
      for (int j = 0; j < N; j++) ireqs[j] = '0;
      do_reset();

      // Single request from requester 1
      len_fix = 3;
      raise(1);
      run_txn(w, p, la, 0, 0, 0, -1);
      chk("single_w", 128'(w), 128'(1));
      chk("single_last_at", 128'(la), 128'(3));
      chk_idle("single_after");
      tick();
      raise(0);
      raise(2);
      run_txn(w, p, la, 0, 0, 0, -1);
      chk("single_next_w", 128'(w), 128'(2));

      // Fairness with everyone requesting continuously
      do_reset();
      len_fix = 1;
      for (int j = 0; j < N; j++) raise(j);
      for (int k = 0; k < 6; k++) begin
         run_txn(w, p, la, 0, 100, 0, -1);
         chk("fair_order", 128'(w), 128'(k % N));
      end

      // Grantee re-requests on its last while another waits
      do_reset();
      len_fix = 2;
      raise(0);
      raise(1);
      run_txn(w, p, la, 0, 100, 0, -1);
      chk("b2b_first", 128'(w), 128'(0));
      run_txn(w, p, la, 0, 0, 0, -1);
      chk("b2b_next", 128'(w), 128'(1));

      // 4-beat burst passthrough
      do_reset();
      len_fix = 4;
      raise(1);
      run_txn(w, p, la, 0, 0, 0, -1);
      chk("burst_pulses", 128'(p), 128'(4));
      chk("burst_last_at", 128'(la), 128'(4));

      // Asynchronous reset during beat 2
      do_reset();
      len_fix = 4;
      raise(2);
      run_txn(w, p, la, 0, 0, 0, 2);
      do_reset();
      len_fix = 0;
      for (int j = 0; j < N; j++) raise(j);
      run_txn(w, p, la, 0, 0, 0, -1);
      chk("post_abort_w", 128'(w), 128'(0));

`ifdef CBUS_ARB_STATS_EN
      do_reset();
      len_fix = 1;
      for (int k = 0; k < 8; k++) begin
         raise((k < 5) ? 0 : 1);
         run_txn(w, p, la, 0, 0, 0, -1);
      end
      chk("stats_0", 128'(grant_cnt[0]), 128'(5));
      chk("stats_1", 128'(grant_cnt[1]), 128'(3));
`endif

      // Random traffic
      do_reset();
      len_fix = 0;
      for (int r = 0; r < 60; r++) begin
         if (pick() < 0) begin
            int gap;
            gap = $urandom_range(3);
            for (int g = 0; g < gap; g++) begin
               chk_idle("gap");
               tick();
            end
            for (int j = 0; j < N; j++) if ($urandom_range(1) == 1) raise(j);
         end
         run_txn(w, p, la, 30, 50, 20, -1);
      end
      chk_idle("rand_end");
`ifdef CBUS_ARB_STATS_EN
      for (int j = 0; j < N; j++) chk("rand_stats", 128'(grant_cnt[j]), 128'(cnt_m[j]));
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
